// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-ROM bus and the IF/ID register
// outputs of the fetch stage. The master side is the fetch stage; the slave
// side is its surroundings (ROM plus decode stage).
interface fetch_stage_if #(
  parameter int N  = 64,
  parameter int IW = 32
);
  logic [5:0]    imem_addr;
  logic [IW-1:0] imem_q;
  logic [N-1:0]  if_pc;
  logic [IW-1:0] if_instr;
  logic          if_valid;

  modport master (
    output imem_addr,
    input  imem_q,
    output if_pc,
    output if_instr,
    output if_valid
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    input  if_pc,
    input  if_instr,
    input  if_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: LEGv8 instruction-fetch stage. Holds the PC, addresses the
// 64-word instruction ROM and captures the fetched word into IF/ID.
// Optional feature: define FETCH_HALT_EN to stop fetching when a zero
// instruction word is read; a later branch redirect restarts fetch.
module fetch_stage #(
  parameter int             N        = 64,
  parameter int             IW       = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 pcsrc,
  input  logic [N-1:0]         branch_target,
  fetch_stage_if.master        bus,
  output logic [31:0]          fetch_count,
  output logic                 halted
);

  logic [N-1:0]  pc;
  logic [N-1:0]  target_aligned;
  logic [N-1:0]  if_pc_q;
  logic [IW-1:0] if_instr_q;
  logic          if_valid_q;
  logic          halt_state;
  logic          halt_hit;

  // Branch targets are forced to a word boundary by clearing the low two bits
  assign target_aligned = branch_target & ~{{(N-2){1'b0}}, 2'b11};

  assign bus.imem_addr = pc[7:2];
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_valid  = if_valid_q;

`ifdef FETCH_HALT_EN
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] HALTED = 1'b1;

  logic [0:0] state;

  // A zero word seen on an ordinary load edge (no stall, flush or redirect)
  // stops the fetch stream
  assign halt_hit   = (state == RUN) && !stall && !flush && !pcsrc &&
                      (bus.imem_q == '0);
  assign halt_state = (state == HALTED);
  assign halted     = halt_state;

  // Halt state machine: a redirect is the only way out of HALTED
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else if (state == HALTED) begin
      if (pcsrc) state <= RUN;
    end else if (halt_hit) begin
      state <= HALTED;
    end
  end
`else
  assign halt_hit   = 1'b0;
  assign halt_state = 1'b0;
  assign halted     = 1'b0;
`endif

  // PC update: a redirect wins over stall and halt so a taken branch is never lost
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (pcsrc) begin
      pc <= target_aligned;
    end else if (stall || halt_state || halt_hit) begin
      pc <= pc;
    end else begin
      pc <= pc + N'(4);
    end
  end

  // IF/ID register and fetch counter: flush kills, stall holds, halt injects bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc_q     <= '0;
      if_instr_q  <= '0;
      if_valid_q  <= 1'b0;
      fetch_count <= '0;
    end else if (flush) begin
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else if (stall) begin
      if_pc_q    <= if_pc_q;
      if_instr_q <= if_instr_q;
      if_valid_q <= if_valid_q;
    end else if (halt_state || halt_hit) begin
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      if_pc_q     <= pc;
      if_instr_q  <= bus.imem_q;
      if_valid_q  <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector bench for fetch_stage with a behavioural
// 64-word ROM. Covers reset, sequential fetch, stall, branch+flush, address
// aliasing, PC wrap, zero-word handling (with or without FETCH_HALT_EN) and
// reset under stall.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        pcsrc;
  logic [63:0] branch_target;
  logic [31:0] fetch_count;
  logic        halted;
  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();

  fetch_stage #(.N(64), .IW(32), .RESET_PC(64'd0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .bus           (bus),
    .fetch_count   (fetch_count),
    .halted        (halted)
  );

  assign bus.imem_q = rom[bus.imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Set the control inputs, then advance one rising edge and settle
  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic p, input logic [63:0] t);
    reset = r; stall = s; flush = f; pcsrc = p; branch_target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [63:0] pc_exp,
                           input logic [31:0] instr_exp, input logic valid_exp,
                           input logic [31:0] count_exp);
    checkOutput({tag, ".if_pc"},    bus.if_pc,         pc_exp);
    checkOutput({tag, ".if_instr"}, 64'(bus.if_instr), 64'(instr_exp));
    checkOutput({tag, ".if_valid"}, 64'(bus.if_valid), 64'(valid_exp));
    checkOutput({tag, ".count"},    64'(fetch_count),  64'(count_exp));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h8B00_0000 + 32'(i);
    rom[0]  = 32'hF800_0001;
    rom[1]  = 32'hF800_8002;
    rom[2]  = 32'hF800_0203;
    rom[47] = 32'h0000_0000;

    // Reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("reset", 64'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("reset.imem_addr", 64'(bus.imem_addr), 64'd0);
    checkOutput("reset.halted", 64'(halted), 64'd0);

    // Sequential fetch
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("seq0", 64'd0, 32'hF800_0001, 1'b1, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("seq1", 64'd4, 32'hF800_8002, 1'b1, 32'd2);
    checkOutput("seq1.imem_addr", 64'(bus.imem_addr), 64'd2);

    // Stall for three edges at pc = 8
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
      checkIfId("stall", 64'd4, 32'hF800_8002, 1'b1, 32'd2);
      checkOutput("stall.imem_addr", 64'(bus.imem_addr), 64'd2);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("unstall", 64'd8, 32'hF800_0203, 1'b1, 32'd3);

    // Branch + flush to misaligned target 0x1E from pc = 12
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'h1E);
    checkIfId("brflush", 64'd0, 32'd0, 1'b0, 32'd3);
    checkOutput("brflush.imem_addr", 64'(bus.imem_addr), 64'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("brtarget", 64'h1C, 32'h8B00_0007, 1'b1, 32'd4);

    // Redirect alone to 0xFC keeps the instruction fetched at 0x20
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'hFC);
    checkIfId("br_nokill", 64'h20, 32'h8B00_0008, 1'b1, 32'd5);
    checkOutput("br_nokill.imem_addr", 64'(bus.imem_addr), 64'd63);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("rom63", 64'hFC, 32'h8B00_003F, 1'b1, 32'd6);
    checkOutput("alias.imem_addr", 64'(bus.imem_addr), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("alias", 64'h100, 32'hF800_0001, 1'b1, 32'd7);

    // PC wrap at 2^64
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    checkIfId("wrap_br", 64'h104, 32'hF800_8002, 1'b1, 32'd8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 32'h8B00_003F, 1'b1, 32'd9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("wrap_zero", 64'd0, 32'hF800_0001, 1'b1, 32'd10);

    // Zero instruction word at 0xBC
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 64'hB8);
    checkIfId("to_b8", 64'd0, 32'd0, 1'b0, 32'd10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("b8", 64'hB8, 32'h8B00_002E, 1'b1, 32'd11);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
`ifdef FETCH_HALT_EN
    checkIfId("halt", 64'd0, 32'd0, 1'b0, 32'd11);
    checkOutput("halt.halted", 64'(halted), 64'd1);
    checkOutput("halt.imem_addr", 64'(bus.imem_addr), 64'd47);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("halt_hold", 64'd0, 32'd0, 1'b0, 32'd11);
    checkOutput("halt_hold.halted", 64'(halted), 64'd1);
    checkOutput("halt_hold.imem_addr", 64'(bus.imem_addr), 64'd47);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 64'd0);
    checkIfId("restart", 64'd0, 32'd0, 1'b0, 32'd11);
    checkOutput("restart.halted", 64'(halted), 64'd0);
    checkOutput("restart.imem_addr", 64'(bus.imem_addr), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("restart_rom0", 64'd0, 32'hF800_0001, 1'b1, 32'd12);
`else
    checkIfId("zero_word", 64'hBC, 32'd0, 1'b1, 32'd12);
    checkOutput("zero_word.halted", 64'(halted), 64'd0);
    checkOutput("zero_word.imem_addr", 64'(bus.imem_addr), 64'd48);
`endif

    // Reset asserted together with stall, flush and redirect
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 64'h40);
    checkIfId("rst_stall", 64'd0, 32'd0, 1'b0, 32'd0);
    checkOutput("rst_stall.imem_addr", 64'(bus.imem_addr), 64'd0);
    checkOutput("rst_stall.halted", 64'(halted), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    checkIfId("post_rst", 64'd0, 32'hF800_0001, 1'b1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the LEGv8 pipelined datapath. It holds the program counter, drives the word address of the 64-word instruction ROM and captures the returned instruction into the IF/ID pipeline register. It also accepts branch redirects from the execute/memory stage and stall/flush requests from the hazard unit. It sits directly upstream of the instruction ROM and feeds the decode stage.

## Interface
- N, 64, PC and branch-target width
- IW, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset (word aligned)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  hazard unit: replace IF/ID contents with bubble
- pcsrc  in  1  branch taken; load branch_target into PC
- branch_target  in  N  redirect address
- imem_addr  out  6  ROM word address = pc[7:2]
- imem_q  in  IW  ROM read data (combinational from imem_addr)
- if_pc  out  N  PC of instruction held in IF/ID
- if_instr  out  IW  instruction held in IF/ID
- if_valid  out  1  IF/ID holds a real instruction
- fetch_count  out  32  number of instructions latched valid since reset
- halted  out  1  fetch stopped on zero word (always 0 without macro)

## Operation
- Internal registers: pc (N), IF/ID {if_pc, if_instr, if_valid}, fetch_count, state (RUN/HALTED; HALTED only with macro).
- imem_addr is pc[7:2], driven combinationally. Addresses ≥256 alias mod 64 words.
- PC update priority: reset > pcsrc > HALTED/stall > normal.
  - reset: pc = RESET_PC.
  - pcsrc: pc = {branch_target[N-1:2], 2'b00}, even when stall is high.
  - stall, or state HALTED: pc holds.
  - normal: pc = pc + 4, modulo 2^N (wraps to 0).
- IF/ID update priority: reset > flush > stall > HALTED > normal.
  - reset: all zero, if_valid = 0.
  - flush: if_instr = 0, if_pc = 0, if_valid = 0.
  - stall: hold all fields.
  - HALTED: bubble (same as flush).
  - normal: if_pc = pc, if_instr = imem_q, if_valid = 1.
- fetch_count increments by 1, wrapping at 2^32, on each edge where IF/ID loads with if_valid = 1. It is cleared by reset.
- pcsrc and flush are independent. The hazard unit asserts both on a taken branch. pcsrc alone redirects without killing the latched instruction.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC[7:2], if_pc = 0, if_instr = 0, if_valid = 0, fetch_count = 0, halted = 0, state = RUN.
- Fetch latency: an instruction at pc appears on if_instr one edge after pc is presented.
  - Example: the first edge with reset low latches word RESET_PC/4 with if_valid = 1, and pc becomes RESET_PC+4.
- Redirect: pcsrc sampled at edge k → pc = target after k. The target instruction is valid in IF/ID after edge k+1 (when not stalled).
- stall held for M edges freezes pc and IF/ID for exactly M edges. Fetch resumes on the first edge with stall low.
- Reset mid-operation: takes effect at the next edge regardless of stall, flush, pcsrc or state.

## Configuration
- FETCH_HALT_EN defined:
  - In RUN, on a normal-load edge with imem_q == 32'h00000000: IF/ID loads a bubble, pc holds, fetch_count does not increment, state → HALTED, halted = 1.
  - In HALTED, pcsrc=1 reloads pc from branch_target and returns state to RUN, with halted = 0 after that edge. Stall, flush and plain edges keep HALTED.
  - A zero word under stall or flush does not halt.
- FETCH_HALT_EN undefined:
  - No HALTED state; halted is tied to 0.
  - A zero word is fetched as an ordinary valid instruction and pc keeps incrementing.

## Test plan
- Reset/sequential: ROM words 0..2 = f8000001, f8008002, f8000203. Release reset → consecutive edges give (if_pc, if_instr) = (0, f8000001), (4, f8008002), (8, f8000203), with if_valid = 1 and fetch_count = 1, 2, 3.
- Stall: assert stall for 3 edges while pc = 8 → if_pc stays 4 and pc stays 8. One edge after release, if_pc = 8 and if_instr = f8000203.
- Branch+flush: at pc = 12, pulse pcsrc = 1, flush = 1, branch_target = 0x1E (misaligned) → next edge if_valid = 0 and pc = 0x1C. The following edge gives if_pc = 0x1C and if_instr = ROM[7].
- Wrap: branch_target = 0xFC → if_instr = ROM[63], and then the next pc is 0x100 with imem_addr = 0 (ROM[0]). With pc = 2^64−4, the next pc = 0.
- Reset mid-stall: stall = 1 and reset = 1 at the same edge → all outputs return to their reset values at that edge.
- FETCH_HALT_EN: ROM word 47 = 0 → after if_pc = 0xB8 is latched, halted = 1, if_valid = 0, pc holds at 0xBC and fetch_count is frozen. A pcsrc to target 0 clears halted and restarts fetch at ROM[0]. Without the macro: if_instr = 0 is latched valid and pc advances to 0xC0.
